// File: rtl/tt_loopback_checker.sv
// Pad loopback self-test: drives LFSR patterns on uo/uio, checks the looped-back values
// on ui/uio_in and reports a saturating mismatch count once the run is done.
module tt_loopback_checker #(
  parameter int unsigned RUN_CYCLES = 256,
  parameter int unsigned LOOP_LAT   = 0,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [2:0] {StIdle, StRunOut, StRunIn, StDrain, StDone} state_e;

  typedef struct packed {
    logic       valid;
    logic [7:0] uo;
    logic [7:0] uio;
    logic [7:0] oe;
  } entry_t;

  localparam logic [15:0] LastRun   = 16'(RUN_CYCLES - 1);
  localparam logic [15:0] LastDrain = 16'(LOOP_LAT - 1);

  state_e      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d, lfsr_step;
  logic [15:0] cnt_q, cnt_d;
  logic [6:0]  err_q, err_d;
  logic [7:0]  uo_d, uio_d, oe_d;
  entry_t      push;
  entry_t      chk;
  logic        mismatch;

  // Stage 0 mirrors the registered outputs; stage LOOP_LAT is the one being checked.
  entry_t [LOOP_LAT:0] pipe_q;

  assign lfsr_step = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign chk       = pipe_q[LOOP_LAT];
  assign mismatch  = chk.valid && ((ui_in != chk.uo) || (uio_in != (chk.uio & chk.oe)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      lfsr_q  <= SEED;
      cnt_q   <= '0;
      err_q   <= '0;
      uo_out  <= '0;
      uio_out <= '0;
      uio_oe  <= '0;
      pipe_q  <= '0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      uo_out    <= uo_d;
      uio_out   <= uio_d;
      uio_oe    <= oe_d;
      pipe_q[0] <= push;
      for (int unsigned i = 1; i <= LOOP_LAT; i++) begin
        pipe_q[i] <= ena ? pipe_q[i-1] : '0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (!ena) begin
      state_d = StIdle;
    end else begin
      if (mismatch && (err_q != 7'h7F)) begin
        err_d = err_q + 7'd1;
      end
      case (state_q)
        StIdle: begin
          state_d = StRunOut;
          lfsr_d  = SEED;
          cnt_d   = '0;
          err_d   = '0;
        end
        StRunOut: begin
          lfsr_d = lfsr_step;
          cnt_d  = cnt_q + 16'd1;
          if (cnt_q == LastRun) begin
            state_d = StRunIn;
            cnt_d   = '0;
          end
        end
        StRunIn: begin
          lfsr_d = lfsr_step;
          cnt_d  = cnt_q + 16'd1;
          if (cnt_q == LastRun) begin
            state_d = (LOOP_LAT == 0) ? StDone : StDrain;
            cnt_d   = '0;
          end
        end
        StDrain: begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_q == LastDrain) begin
            state_d = StDone;
            cnt_d   = '0;
          end
        end
        StDone:  state_d = StDone;
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs are decoded from next-state values so the DONE word includes the final check.
  always_comb begin
    uo_d  = '0;
    uio_d = '0;
    oe_d  = '0;
    push  = '0;
    case (state_d)
      StRunOut, StRunIn: begin
        uo_d  = lfsr_d[7:0];
        uio_d = lfsr_d[15:8];
        oe_d  = (state_d == StRunOut) ? 8'hFF : 8'h00;
        push  = {1'b1, uo_d, uio_d, oe_d};
      end
      StDone: begin
        uo_d  = {(err_d == 7'd0), err_d};
        uio_d = 8'h01;
        oe_d  = 8'h01;
      end
      default: begin
        uo_d = '0;
      end
    endcase
  end

endmodule
